// File: rtl/result_display_driver.sv
// Converts the 8-bit result to BCD one bit per cycle (double dabble) and
// scans sign/hundreds/tens/ones onto a shared 7-segment bus.
module result_display_driver #(
  parameter int REFRESH_DIV = 1024
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [7:0]  value_in,
  input  logic        signed_mode,
  input  logic        update,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out,
  output logic        neg_out,
  output logic [6:0]  seg_out,
  output logic [3:0]  digit_sel
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state;
  logic [7:0]  mag;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_shift;
  logic        sign;
  logic [2:0]  bit_cnt;

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic [1:0]    next_idx;
  logic          wrap;
  logic [6:0]    next_seg;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[10:0], mag[7]};
  end

  // The magnitude always fits in 8 bits: -128 negates to 0x80 = 128 unsigned.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      neg_out <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      sign    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (update) begin
            if (signed_mode && value_in[7]) begin
              mag  <= ~value_in + 8'd1;
              sign <= 1'b1;
            end else begin
              mag  <= value_in;
              sign <= 1'b0;
            end
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          bcd     <= bcd_shift;
          mag     <= {mag[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bcd_out <= bcd_shift;
            neg_out <= sign;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wrap     = (refresh_cnt == CW'(REFRESH_DIV - 1));
    next_idx = wrap ? scan_idx + 2'd1 : scan_idx;
    case (next_idx)
      2'd3:    next_seg = neg_out ? 7'h40 : 7'h00;
      2'd2:    next_seg = (bcd_out[11:8] == 4'd0) ? 7'h00 : seg_code(bcd_out[11:8]);
      2'd1:    next_seg = (bcd_out[11:4] == 8'd0) ? 7'h00 : seg_code(bcd_out[7:4]);
      default: next_seg = seg_code(bcd_out[3:0]);
    endcase
  end

  // digit_sel and seg_out are both derived from next_idx so they stay aligned.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      digit_sel   <= 4'b0001;
      seg_out     <= 7'h3F;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + CW'(1);
      scan_idx    <= next_idx;
      digit_sel   <= 4'b0001 << next_idx;
      seg_out     <= next_seg;
    end
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with REFRESH_DIV = 4.
module tb_result_display_driver;

  logic        clock = 1'b0;
  logic        Reset;
  logic [7:0]  value_in;
  logic        signed_mode;
  logic        update;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic        neg_out;
  logic [6:0]  seg_out;
  logic [3:0]  digit_sel;

  int checks   = 0;
  int failures = 0;

  result_display_driver #(.REFRESH_DIV(4)) dut (
    .clock       (clock),
    .Reset       (Reset),
    .value_in    (value_in),
    .signed_mode (signed_mode),
    .update      (update),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .neg_out     (neg_out),
    .seg_out     (seg_out),
    .digit_sel   (digit_sel)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full conversion with busy/done timing checks.
  task automatic convert(input string tag, input logic [7:0] val, input logic sm,
                         input logic [11:0] exp_bcd, input logic exp_neg);
    value_in    = val;
    signed_mode = sm;
    update      = 1'b1;
    tick();
    update = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_nodone"}, done, 0);
      tick();
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_bcd"}, bcd_out, exp_bcd);
    check({tag, "_neg"}, neg_out, exp_neg);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    tick();
  endtask

  task automatic scan_check(input string tag, input logic [3:0] sel, input logic [6:0] exp);
    int n = 0;
    while (digit_sel !== sel && n < 32) begin
      tick();
      n++;
    end
    check({tag, "_found"}, digit_sel, sel);
    check({tag, "_seg"}, seg_out, exp);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  initial begin
    int dones;
    logic [3:0] prev;

    Reset = 1'b1; value_in = '0; signed_mode = 1'b0; update = 1'b0;
    repeat (5) tick();
    check("rst_sel", digit_sel, 4'b0001);
    check("rst_seg", seg_out, 7'h3F);
    check("rst_bcd", bcd_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_neg", neg_out, 0);
    Reset = 1'b0;
    tick();

    convert("ff_u", 8'hFF, 1'b0, 12'h255, 1'b0);
    scan_check("ff_sign", 4'b1000, 7'h00);
    scan_check("ff_hund", 4'b0100, 7'h5B);
    scan_check("ff_tens", 4'b0010, 7'h6D);
    scan_check("ff_ones", 4'b0001, 7'h6D);

    convert("m128", 8'h80, 1'b1, 12'h128, 1'b1);
    scan_check("m128_sign", 4'b1000, 7'h40);
    scan_check("m128_hund", 4'b0100, 7'h06);
    scan_check("m128_tens", 4'b0010, 7'h5B);
    scan_check("m128_ones", 4'b0001, 7'h7F);

    convert("m5", 8'hFB, 1'b1, 12'h005, 1'b1);
    scan_check("m5_sign", 4'b1000, 7'h40);
    scan_check("m5_hund", 4'b0100, 7'h00);
    scan_check("m5_tens", 4'b0010, 7'h00);
    scan_check("m5_ones", 4'b0001, 7'h6D);

    convert("zero_s", 8'h00, 1'b1, 12'h000, 1'b0);
    convert("p127", 8'h7F, 1'b1, 12'h127, 1'b0);
    convert("u128", 8'h80, 1'b0, 12'h128, 1'b0);

    // Rotation: sync on the 1000 -> 0001 transition, then 16 cycles.
    convert("seven", 8'h07, 1'b0, 12'h007, 1'b0);
    begin
      int n = 0;
      prev = digit_sel;
      tick();
      while (!(prev == 4'b1000 && digit_sel == 4'b0001) && n < 40) begin
        prev = digit_sel;
        tick();
        n++;
      end
      check("rot_sync", digit_sel, 4'b0001);
    end
    for (int k = 0; k < 16; k++) begin
      check("rot_sel", digit_sel, 4'b0001 << (k / 4));
      check("rot_seg", seg_out, (k < 4) ? 7'h07 : 7'h00);
      tick();
    end

    // Update during busy is ignored.
    value_in = 8'h2A; signed_mode = 1'b0; update = 1'b1;
    tick();
    update = 1'b0;
    repeat (3) tick();
    value_in = 8'h99; update = 1'b1;
    tick();
    update = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      tick();
    end
    check("ign_dones", dones, 1);
    check("ign_bcd", bcd_out, 12'h042);

    // update held through done: back-to-back acceptance.
    value_in = 8'h0C; signed_mode = 1'b0; update = 1'b1;
    tick();
    value_in = 8'h00;
    wait_done("b2b_first");
    check("b2b_first_bcd", bcd_out, 12'h012);
    value_in = 8'h63;
    tick();
    update = 1'b0;
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_nodone", done, 0);
    wait_done("b2b_second");
    check("b2b_second_bcd", bcd_out, 12'h099);
    tick();

    // Reset mid-conversion aborts without a done pulse.
    value_in = 8'h55; signed_mode = 1'b0; update = 1'b1;
    tick();
    update = 1'b0;
    repeat (4) tick();
    check("abort_pre_busy", busy, 1);
    Reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd_out, 0);
    check("abort_sel", digit_sel, 4'b0001);
    check("abort_seg", seg_out, 7'h3F);
    tick();
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      tick();
    end
    check("abort_nodone", dones, 0);
    check("abort_bcd_after", bcd_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
